uop_loop_addr_gen: RTL

//  Parametrised nested-loop address generator for the systolic-array load path.

---
 rtl/uop_loop_addr_gen.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uop_loop_addr_gen.sv
// rtl/uop_loop_addr_gen.sv - nested-loop uop address generator for the systolic-array load path
// Reads uop deltas, adds an incrementally built loop offset and buffers addresses in a 2-entry FIFO.
module uop_loop_addr_gen #(
  parameter int NUM_LOOPS  = 2,
  parameter int ITER_W     = 16,
  parameter int STRIDE_W   = 16,
  parameter int UOP_IDX_W  = 16,
  parameter int UOP_DATA_W = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [UOP_IDX_W-1:0]          uop_bgn,
  input  logic [UOP_IDX_W-1:0]          uop_num,
  input  logic [NUM_LOOPS*ITER_W-1:0]   iter_cnt,
  input  logic [NUM_LOOPS*STRIDE_W-1:0] stride,
  output logic                          busy,
  output logic                          done,
  output logic                          uop_rd_req,
  output logic [UOP_IDX_W-1:0]          uop_rd_addr,
  input  logic [UOP_DATA_W-1:0]         uop_rd_data,
  output logic                          addr_valid,
  input  logic                          addr_ready,
  output logic [ADDR_W-1:0]             addr_out,
  output logic                          uop_last,
  output logic                          addr_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [UOP_IDX_W-1:0] uop_bgn_q, uop_bgn_d;
  logic [UOP_IDX_W-1:0] uop_num_q, uop_num_d;
  logic [UOP_IDX_W-1:0] uop_cnt_q, uop_cnt_d;
  logic [ITER_W-1:0]    iter_m1_q [NUM_LOOPS];
  logic [ITER_W-1:0]    iter_m1_d [NUM_LOOPS];
  logic [ADDR_W-1:0]    stride_q  [NUM_LOOPS];
  logic [ADDR_W-1:0]    stride_d  [NUM_LOOPS];
  logic [ITER_W-1:0]    cnt_q     [NUM_LOOPS];
  logic [ITER_W-1:0]    cnt_d     [NUM_LOOPS];
  logic [ADDR_W-1:0]    off_q     [NUM_LOOPS];
  logic [ADDR_W-1:0]    off_d     [NUM_LOOPS];

  logic                 rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]    rd_off_q, rd_off_d;
  logic                 rd_uop_last_q, rd_uop_last_d;
  logic                 rd_addr_last_q, rd_addr_last_d;

  logic [1:0]           occ_q, occ_d;
  logic [ADDR_W-1:0]    fifo_addr_q [2];
  logic [ADDR_W-1:0]    fifo_addr_d [2];
  logic [1:0]           fifo_ul_q, fifo_ul_d;
  logic [1:0]           fifo_al_q, fifo_al_d;

  logic                 pop;
  logic                 issue;
  logic                 uop_wrap;
  logic                 loops_at_max;
  logic                 loop_found;
  logic                 wr_head;
  logic [2:0]           level;
  logic [ADDR_W-1:0]    new_off;
  logic [ADDR_W-1:0]    push_addr;

  assign addr_valid  = (occ_q != 2'd0);
  assign addr_out    = fifo_addr_q[0];
  assign uop_last    = fifo_ul_q[0];
  assign addr_last   = fifo_al_q[0];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign uop_rd_addr = uop_bgn_q + uop_cnt_q;
  assign uop_rd_req  = issue;

  // Slots that will be taken once this cycle's pop and the in-flight read settle.
  assign pop      = addr_valid & addr_ready;
  assign level    = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue    = (state_q == RUN) && (uop_num_q != '0) && (level < 3'd2);
  assign uop_wrap = (uop_cnt_q == uop_num_q - UOP_IDX_W'(1));
  assign push_addr = base_q + rd_off_q + ADDR_W'(uop_rd_data);

  always_comb begin
    loops_at_max = 1'b1;
    for (int k = 0; k < NUM_LOOPS; k++) begin
      if (cnt_q[k] != iter_m1_q[k]) loops_at_max = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    uop_bgn_d      = uop_bgn_q;
    uop_num_d      = uop_num_q;
    uop_cnt_d      = uop_cnt_q;
    iter_m1_d      = iter_m1_q;
    stride_d       = stride_q;
    cnt_d          = cnt_q;
    off_d          = off_q;
    rd_pend_d      = 1'b0;
    rd_off_d       = rd_off_q;
    rd_uop_last_d  = rd_uop_last_q;
    rd_addr_last_d = rd_addr_last_q;
    new_off        = '0;
    loop_found     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          uop_bgn_d = uop_bgn;
          uop_num_d = uop_num;
          uop_cnt_d = '0;
          for (int k = 0; k < NUM_LOOPS; k++) begin
            iter_m1_d[k] = (iter_cnt[k*ITER_W +: ITER_W] == '0) ? '0
                         : iter_cnt[k*ITER_W +: ITER_W] - ITER_W'(1);
            stride_d[k]  = ADDR_W'(stride[k*STRIDE_W +: STRIDE_W]);
            cnt_d[k]     = '0;
            off_d[k]     = '0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        if ((uop_num_q == '0) || (issue && uop_wrap && loops_at_max)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((occ_q == 2'd0) && !rd_pend_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_pend_d      = 1'b1;
      rd_off_d       = off_q[0];
      rd_uop_last_d  = uop_wrap;
      rd_addr_last_d = uop_wrap & loops_at_max;
      uop_cnt_d      = uop_wrap ? '0 : uop_cnt_q + UOP_IDX_W'(1);
      // Lowest non-saturated loop steps; everything inside it restarts from its new offset.
      if (uop_wrap) begin
        for (int k = 0; k < NUM_LOOPS; k++) begin
          if (!loop_found) begin
            if (cnt_q[k] != iter_m1_q[k]) begin
              loop_found = 1'b1;
              cnt_d[k]   = cnt_q[k] + ITER_W'(1);
              new_off    = off_q[k] + stride_q[k];
              for (int j = 0; j <= k; j++) off_d[j] = new_off;
            end else begin
              cnt_d[k] = '0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_ul_d   = fifo_ul_q;
    fifo_al_d   = fifo_al_q;
    occ_d       = occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
    wr_head     = (occ_q == 2'd0) || ((occ_q == 2'd1) && pop);
    if (pop) begin
      fifo_addr_d[0] = fifo_addr_q[1];
      fifo_ul_d[0]   = fifo_ul_q[1];
      fifo_al_d[0]   = fifo_al_q[1];
    end
    if (rd_pend_q) begin
      if (wr_head) begin
        fifo_addr_d[0] = push_addr;
        fifo_ul_d[0]   = rd_uop_last_q;
        fifo_al_d[0]   = rd_addr_last_q;
      end else begin
        fifo_addr_d[1] = push_addr;
        fifo_ul_d[1]   = rd_uop_last_q;
        fifo_al_d[1]   = rd_addr_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      uop_bgn_q      <= '0;
      uop_num_q      <= '0;
      uop_cnt_q      <= '0;
      rd_pend_q      <= 1'b0;
      rd_off_q       <= '0;
      rd_uop_last_q  <= 1'b0;
      rd_addr_last_q <= 1'b0;
      occ_q          <= 2'd0;
      fifo_ul_q      <= 2'b00;
      fifo_al_q      <= 2'b00;
      for (int k = 0; k < 2; k++) fifo_addr_q[k] <= '0;
      for (int k = 0; k < NUM_LOOPS; k++) begin
        iter_m1_q[k] <= '0;
        stride_q[k]  <= '0;
        cnt_q[k]     <= '0;
        off_q[k]     <= '0;
      end
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      uop_bgn_q      <= uop_bgn_d;
      uop_num_q      <= uop_num_d;
      uop_cnt_q      <= uop_cnt_d;
      rd_pend_q      <= rd_pend_d;
      rd_off_q       <= rd_off_d;
      rd_uop_last_q  <= rd_uop_last_d;
      rd_addr_last_q <= rd_addr_last_d;
      occ_q          <= occ_d;
      fifo_ul_q      <= fifo_ul_d;
      fifo_al_q      <= fifo_al_d;
      fifo_addr_q    <= fifo_addr_d;
      iter_m1_q      <= iter_m1_d;
      stride_q       <= stride_d;
      cnt_q          <= cnt_d;
      off_q          <= off_d;
    end
  end

endmodule
